inst_sequencer: RTL

- Initiator side of the 52-bit core instruction bus. Generates, cycle by cycle, the inst word that the core decodes to drive activation SRAM, weight SRAM, L0, OFIFO and output SRAM.
- Runs a full weight-stationary convolution pass: for each kernel index kij it loads one weight tile, streams the activations, executes, and drains the OFIFO into output SRAM.
- Sits beside the core top. Takes only start and ofifo_valid as inputs and replaces testbench-driven instruction sequences.

---
 rtl/inst_sequencer_if.sv | 13 +
 rtl/inst_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer_if.sv
// Instruction-bus connection between the sequencer and the core.
// The sequencer drives inst and the status outputs; start/ofifo_valid come from outside.
interface inst_sequencer_if;
  logic        start;
  logic        ofifo_valid;
  logic [51:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  modport master (input start, ofifo_valid, output inst, busy, done, kij_idx);
  modport slave  (output start, ofifo_valid, input inst, busy, done, kij_idx);
endinterface

// File: rtl/inst_sequencer.sv
// Weight-stationary convolution sequencer: for each kernel index it loads a weight tile,
// streams activations, executes, and drains the OFIFO into output SRAM via the inst word.
module inst_sequencer #(
  parameter int COL     = 8,
  parameter int ROW     = 8,
  parameter int LEN_ACT = 36,
  parameter int KIJ_NUM = 9,
  parameter int ABW     = 11
) (
  input logic                clk,
  input logic                reset,
  inst_sequencer_if.master   bus
);

  localparam int MAXN  = (LEN_ACT > COL) ? ((LEN_ACT > ROW) ? LEN_ACT : ROW)
                                         : ((COL > ROW) ? COL : ROW);
  localparam int CNT_W = $clog2(MAXN + 2);

  // Inst bit positions
  localparam int CEN_O = 50, WEN_O = 49, A_O = 38;
  localparam int MODE = 35, DATA_MODE = 34, ACC = 33;
  localparam int CEN_P = 32, WEN_P = 31, A_P = 20;
  localparam int CEN_X = 19, WEN_X = 18, A_X = 7;
  localparam int OFIFO_RD = 6, L0_RD = 3, L0_WR = 2, EXECUTE = 1, LOAD = 0;

  localparam logic [51:0] IDLE_WORD = (52'd1 << CEN_O) | (52'd1 << WEN_O) | (52'd1 << MODE)
                                    | (52'd1 << CEN_P) | (52'd1 << WEN_P)
                                    | (52'd1 << CEN_X) | (52'd1 << WEN_X);

  typedef enum logic [2:0] {IDLE, W_RD, W_LOAD, A_RD, EXEC, OUT, NEXT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   j_q, j_d;
  logic [CNT_W-1:0]   wr_addr_q, wr_addr_d;
  logic               wr_pend_q, wr_pend_d;
  logic [3:0]         kij_q, kij_d;
  logic [51:0]        inst_q, inst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ABW-1:0]     a_pmem;

  assign a_pmem = ABW'(kij_q) * ABW'(COL) + ABW'(cnt_q);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    wr_addr_d = wr_addr_q;
    wr_pend_d = 1'b0;
    kij_d     = kij_q;
    done_d    = 1'b0;
    inst_d    = IDLE_WORD;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = W_RD;
          kij_d   = '0;
          cnt_d   = '0;
        end
      end
      W_RD: begin
        if (cnt_q < CNT_W'(COL)) begin
          inst_d[CEN_P]           = 1'b0;
          inst_d[A_P +: ABW]      = a_pmem;
          inst_d[DATA_MODE]       = 1'b1;
        end
        // Read data arrives one cycle later, so the capture trails the read by one word
        if (cnt_q != '0) inst_d[L0_WR] = 1'b1;
        if (cnt_q == CNT_W'(COL)) begin
          state_d = W_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      W_LOAD: begin
        inst_d[L0_RD] = 1'b1;
        inst_d[LOAD]  = 1'b1;
        if (cnt_q == CNT_W'(COL - 1)) begin
          state_d = A_RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      A_RD: begin
        if (cnt_q < CNT_W'(LEN_ACT)) begin
          inst_d[CEN_X]      = 1'b0;
          inst_d[A_X +: ABW] = ABW'(cnt_q);
        end
        if (cnt_q != '0) inst_d[L0_WR] = 1'b1;
        if (cnt_q == CNT_W'(LEN_ACT)) begin
          state_d = EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        inst_d[L0_RD]   = 1'b1;
        inst_d[EXECUTE] = 1'b1;
        if (cnt_q == CNT_W'(LEN_ACT - 1)) begin
          state_d = OUT;
          cnt_d   = '0;
          j_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (wr_pend_q) begin
          inst_d[CEN_O]      = 1'b0;
          inst_d[WEN_O]      = 1'b0;
          inst_d[A_O +: ABW] = ABW'(wr_addr_q);
          inst_d[ACC]        = (kij_q != 4'd0);
          if (wr_addr_q == CNT_W'(LEN_ACT - 1)) state_d = NEXT;
        end
        if (j_q < CNT_W'(LEN_ACT) && bus.ofifo_valid) begin
          inst_d[OFIFO_RD] = 1'b1;
          wr_pend_d        = 1'b1;
          wr_addr_d        = j_q;
          j_d              = j_q + 1'b1;
        end
      end
      NEXT: begin
        if (kij_q == 4'(KIJ_NUM - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = W_RD;
          kij_d   = kij_q + 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  // NOTE: registers use non-blocking assignment so all of them update from the same old values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      j_q       <= '0;
      wr_addr_q <= '0;
      wr_pend_q <= 1'b0;
      kij_q     <= '0;
      inst_q    <= IDLE_WORD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      wr_addr_q <= wr_addr_d;
      wr_pend_q <= wr_pend_d;
      kij_q     <= kij_d;
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.inst    = inst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.kij_idx = kij_q;

endmodule
